// File: rtl/grid_scan_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | grid_scan_sequencer                                                      |
// | Walks a GRID_W x GRID_H cell grid in raster order with an ack handshake, |
// | presenting the linear address, grid position and cell pixel origin.      |
// | Optional macro GRID_SCAN_PIXEL_WALK_EN adds a DRAW state that emits      |
// | every pixel of the cell (x fastest) on pix_x/pix_y with pix_valid.       |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module grid_scan_sequencer #(
  parameter int GRID_W  = 16,
  parameter int GRID_H  = 16,
  parameter int CELL_PX = 10,
  parameter int SPACING = 2,
  parameter int ADDR_W  = 11,
  parameter int PIX_W   = 11
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic              continuous,
  input  logic              abort,
  input  logic              cell_ack,
  output logic              cell_valid,
  output logic [ADDR_W-1:0] address,
  output logic [7:0]        pos_x,
  output logic [7:0]        pos_y,
  output logic [PIX_W-1:0]  pix_x,
  output logic [PIX_W-1:0]  pix_y,
`ifdef GRID_SCAN_PIXEL_WALK_EN
  output logic              pix_valid,
`endif
  output logic              busy,
  output logic              frame_done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
`ifdef GRID_SCAN_PIXEL_WALK_EN
    DRAW    = 2'd2,
`endif
    WRAP    = 2'd3
  } stateT;

  localparam logic [7:0]        c_lastX = 8'(GRID_W - 1);
  localparam logic [7:0]        c_lastY = 8'(GRID_H - 1);
  localparam logic [PIX_W-1:0]  c_step  = PIX_W'(CELL_PX + SPACING);
  localparam logic [ADDR_W-1:0] c_gridW = ADDR_W'(GRID_W);

  stateT            r_state, w_stateNext;
  logic [7:0]       r_posX, r_posY, w_posXNext, w_posYNext;
  logic [PIX_W-1:0] r_orgX, r_orgY, w_orgXNext, w_orgYNext;
  logic             w_advance;
  logic             w_lastCell;

`ifdef GRID_SCAN_PIXEL_WALK_EN
  localparam int             CNT_W   = (CELL_PX > 1) ? $clog2(CELL_PX) : 1;
  localparam logic [CNT_W-1:0] c_lastD = CNT_W'(CELL_PX - 1);
  logic [CNT_W-1:0] r_dx, r_dy, w_dxNext, w_dyNext;
`endif

  assign w_lastCell = (r_posX == c_lastX) && (r_posY == c_lastY);

  always_comb begin
    w_stateNext = r_state;
    w_posXNext  = r_posX;
    w_posYNext  = r_posY;
    w_orgXNext  = r_orgX;
    w_orgYNext  = r_orgY;
    w_advance   = 1'b0;
`ifdef GRID_SCAN_PIXEL_WALK_EN
    w_dxNext    = r_dx;
    w_dyNext    = r_dy;
`endif
    case (r_state)
      IDLE: begin
        if (start) begin
          w_stateNext = PRESENT;
          w_posXNext  = '0;
          w_posYNext  = '0;
          w_orgXNext  = '0;
          w_orgYNext  = '0;
        end
      end
      PRESENT: begin
        if (cell_ack) begin
`ifdef GRID_SCAN_PIXEL_WALK_EN
          w_stateNext = DRAW;
          w_dxNext    = '0;
          w_dyNext    = '0;
`else
          w_advance   = 1'b1;
`endif
        end
      end
`ifdef GRID_SCAN_PIXEL_WALK_EN
      DRAW: begin
        if (r_dx == c_lastD) begin
          w_dxNext = '0;
          if (r_dy == c_lastD) begin
            w_dyNext  = '0;
            w_advance = 1'b1;
          end else begin
            w_dyNext = r_dy + CNT_W'(1);
          end
        end else begin
          w_dxNext = r_dx + CNT_W'(1);
        end
      end
`endif
      WRAP: begin
        w_posXNext  = '0;
        w_posYNext  = '0;
        w_orgXNext  = '0;
        w_orgYNext  = '0;
        w_stateNext = continuous ? PRESENT : IDLE;
      end
      default: w_stateNext = IDLE;
    endcase

    // Origins track the position by stepping, so no multiplier is needed.
    if (w_advance) begin
      if (w_lastCell) begin
        w_stateNext = WRAP;
      end else begin
        w_stateNext = PRESENT;
        if (r_posX == c_lastX) begin
          w_posXNext = '0;
          w_orgXNext = '0;
          w_posYNext = r_posY + 8'd1;
          w_orgYNext = r_orgY + c_step;
        end else begin
          w_posXNext = r_posX + 8'd1;
          w_orgXNext = r_orgX + c_step;
        end
      end
    end

    if (abort) begin
      w_stateNext = IDLE;
      w_posXNext  = '0;
      w_posYNext  = '0;
      w_orgXNext  = '0;
      w_orgYNext  = '0;
`ifdef GRID_SCAN_PIXEL_WALK_EN
      w_dxNext    = '0;
      w_dyNext    = '0;
`endif
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_posX  <= '0;
      r_posY  <= '0;
      r_orgX  <= '0;
      r_orgY  <= '0;
`ifdef GRID_SCAN_PIXEL_WALK_EN
      r_dx    <= '0;
      r_dy    <= '0;
`endif
    end else begin
      r_state <= w_stateNext;
      r_posX  <= w_posXNext;
      r_posY  <= w_posYNext;
      r_orgX  <= w_orgXNext;
      r_orgY  <= w_orgYNext;
`ifdef GRID_SCAN_PIXEL_WALK_EN
      r_dx    <= w_dxNext;
      r_dy    <= w_dyNext;
`endif
    end
  end

  assign cell_valid = (r_state == PRESENT);
  assign busy       = (r_state != IDLE);
  assign frame_done = (r_state == WRAP);
  assign pos_x      = r_posX;
  assign pos_y      = r_posY;
  assign address    = ADDR_W'(r_posY) * c_gridW + ADDR_W'(r_posX);

`ifdef GRID_SCAN_PIXEL_WALK_EN
  assign pix_valid  = (r_state == DRAW);
  assign pix_x      = (r_state == DRAW) ? r_orgX + PIX_W'(r_dx) : r_orgX;
  assign pix_y      = (r_state == DRAW) ? r_orgY + PIX_W'(r_dy) : r_orgY;
`else
  assign pix_x      = r_orgX;
  assign pix_y      = r_orgY;
`endif

endmodule
`default_nettype wire

// File: tb/tb_grid_scan_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_grid_scan_sequencer                                                   |
// | Self-checking bench: raster-index reference model plus directed tests.   |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_grid_scan_sequencer;

`ifdef GRID_SCAN_PIXEL_WALK_EN
  localparam int W = 2, H = 2, C = 3, S = 1, PIXN = 9;
  localparam bit WALK = 1'b1;
  localparam int STALL_ADDR = 1, ABORT_ADDR = 2;
`else
  localparam int W = 16, H = 16, C = 10, S = 2, PIXN = 0;
  localparam bit WALK = 1'b0;
  localparam int STALL_ADDR = 53, ABORT_ADDR = 100;
`endif
  localparam int N = W * H;
  localparam int FRAME_LEN = N * (1 + PIXN) + 1;

  logic clock = 1'b0;
  logic resetn, start, continuous, abort, cell_ack;
  logic cellValid, busy, frameDone, pixValid;
  logic [10:0] address, pixX, pixY;
  logic [7:0]  posX, posY;

  logic start2, ack2;
  logic cellValid2, busy2, frameDone2, pixValid2;
  logic [10:0] address2, pixX2, pixY2;
  logic [7:0]  posX2, posY2;

  always #5 clock = ~clock;

  grid_scan_sequencer #(.GRID_W(W), .GRID_H(H), .CELL_PX(C), .SPACING(S), .ADDR_W(11), .PIX_W(11)) dut (
    .clock(clock), .resetn(resetn), .start(start), .continuous(continuous), .abort(abort),
    .cell_ack(cell_ack), .cell_valid(cellValid), .address(address), .pos_x(posX), .pos_y(posY),
    .pix_x(pixX), .pix_y(pixY),
`ifdef GRID_SCAN_PIXEL_WALK_EN
    .pix_valid(pixValid),
`endif
    .busy(busy), .frame_done(frameDone));

  grid_scan_sequencer #(.GRID_W(3), .GRID_H(1), .CELL_PX(1), .SPACING(0), .ADDR_W(11), .PIX_W(11)) dut2 (
    .clock(clock), .resetn(resetn), .start(start2), .continuous(1'b0), .abort(1'b0),
    .cell_ack(ack2), .cell_valid(cellValid2), .address(address2), .pos_x(posX2), .pos_y(posY2),
    .pix_x(pixX2), .pix_y(pixY2),
`ifdef GRID_SCAN_PIXEL_WALK_EN
    .pix_valid(pixValid2),
`endif
    .busy(busy2), .frame_done(frameDone2));

`ifndef GRID_SCAN_PIXEL_WALK_EN
  assign pixValid  = 1'b0;
  assign pixValid2 = 1'b0;
`endif

  int nCompared = 0;
  int nMismatch = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    nCompared++;
    if (act != exp) begin
      nMismatch++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference model: phase 0 idle, 1 presenting, 2 drawing, 3 frame end.
  // The cell is tracked as a linear raster index, the pixel as an index.
  int mPhase, mIdx, mPix;
  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      mPhase <= 0; mIdx <= 0; mPix <= 0;
    end else if (abort) begin
      mPhase <= 0; mIdx <= 0; mPix <= 0;
    end else begin
      case (mPhase)
        0: if (start) begin mPhase <= 1; mIdx <= 0; mPix <= 0; end
        1: if (cell_ack) begin
             if (WALK) begin mPhase <= 2; mPix <= 0; end
             else if (mIdx == N - 1) mPhase <= 3;
             else mIdx <= mIdx + 1;
           end
        2: if (mPix == PIXN - 1) begin
             mPix <= 0;
             if (mIdx == N - 1) mPhase <= 3;
             else begin mPhase <= 1; mIdx <= mIdx + 1; end
           end else mPix <= mPix + 1;
        default: begin mIdx <= 0; mPhase <= continuous ? 1 : 0; end
      endcase
    end
  end

  int ex, ey, edx, edy, fdCount = 0;
  int walkPX[$], walkPY[$];
  always @(negedge clock) begin
    if (!resetn) begin
      chk("rst_cell_valid", cellValid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_frame_done", frameDone, 0);
      chk("rst_address", address, 0);
      chk("rst_pix", {pixX, pixY}, 0);
      chk("rst_pos", {posX, posY}, 0);
      chk("rst_busy2", busy2, 0);
    end else begin
      chk("busy", busy, mPhase != 0);
      chk("cell_valid", cellValid, mPhase == 1);
      chk("frame_done", frameDone, mPhase == 3);
      chk("pix_valid", pixValid, mPhase == 2);
      if (mPhase == 1 || mPhase == 2) begin
        ex  = mIdx % W;
        ey  = mIdx / W;
        edx = (mPhase == 2) ? mPix % C : 0;
        edy = (mPhase == 2) ? mPix / C : 0;
        chk("address", address, mIdx);
        chk("pos_x", posX, ex);
        chk("pos_y", posY, ey);
        chk("pix_x", pixX, (ex * (C + S) + edx) % 2048);
        chk("pix_y", pixY, (ey * (C + S) + edy) % 2048);
      end
      if (frameDone) fdCount++;
`ifdef GRID_SCAN_PIXEL_WALK_EN
      if (pixValid && posX == 1 && posY == 0) begin
        walkPX.push_back(int'(pixX));
        walkPY.push_back(int'(pixY));
      end
`else
      if (cellValid && address == 17) begin
        chk("pin17_pos", {posX, posY}, {8'd1, 8'd1});
        chk("pin17_pix_x", pixX, 12);
        chk("pin17_pix_y", pixY, 12);
      end
      if (cellValid && address == 255) begin
        chk("pin255_pix_x", pixX, 180);
        chk("pin255_pix_y", pixY, 180);
      end
`endif
    end
  end

  task automatic runTo(input int a);
    bit found = 1'b0;
    cell_ack = 1'b1;
    for (int i = 0; i < 2 * FRAME_LEN; i++) begin
      if (cellValid && address == 11'(a)) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("run_to_address_reached", found, 1);
  endtask

  int busyCnt, validCnt, fdLocal, fdBefore, q2[$];
  bit prevFd, prevCell2, straight;
  int expPX[9] = '{4, 5, 6, 4, 5, 6, 4, 5, 6};
  int expPY[9] = '{0, 0, 0, 1, 1, 1, 2, 2, 2};

  initial begin
    resetn = 1'b0; start = 1'b0; continuous = 1'b0; abort = 1'b0; cell_ack = 1'b0;
    start2 = 1'b0; ack2 = 1'b0;
    repeat (3) tick();
    resetn = 1'b1;
    tick();
    chk("idle_after_reset", busy, 0);

    // Full frame with ack held high.
    start = 1'b1; tick(); start = 1'b0; cell_ack = 1'b1;
    busyCnt = 0; validCnt = 0; fdLocal = 0;
    for (int i = 0; i < FRAME_LEN + 20; i++) begin
      if (!busy) break;
      busyCnt++;
      validCnt += int'(cellValid);
      fdLocal  += int'(frameDone);
      tick();
    end
    cell_ack = 1'b0;
    chk("frame_busy_cycles", busyCnt, FRAME_LEN);
    chk("frame_valid_cycles", validCnt, N);
    chk("frame_done_pulses", fdLocal, 1);
    chk("frame_ends_idle", busy, 0);
`ifdef GRID_SCAN_PIXEL_WALK_EN
    chk("walk_cell10_count", walkPX.size(), 9);
    for (int k = 0; k < 9 && k < walkPX.size(); k++) begin
      chk("walk_cell10_px", walkPX[k], expPX[k]);
      chk("walk_cell10_py", walkPY[k], expPY[k]);
    end
`endif

    // Stall on one cell, then a single ack.
    start = 1'b1; tick(); start = 1'b0;
    runTo(STALL_ADDR);
    cell_ack = 1'b0;
    repeat (10) begin
      tick();
      chk("stall_address", address, STALL_ADDR);
`ifdef GRID_SCAN_PIXEL_WALK_EN
      chk("stall_pix", {pixX, pixY}, {11'd4, 11'd0});
`else
      chk("stall_pix", {pixX, pixY}, {11'd60, 11'd36});
`endif
    end
    cell_ack = 1'b1; tick(); cell_ack = 1'b0;
`ifdef GRID_SCAN_PIXEL_WALK_EN
    chk("ack_enters_draw", {cellValid, pixValid}, 2'b01);
`else
    chk("ack_advances", address, 54);
    chk("ack_advances_valid", cellValid, 1);
`endif

    // Abort beats a simultaneous ack and start.
    runTo(ABORT_ADDR);
    fdBefore = fdCount;
    abort = 1'b1; start = 1'b1; tick();
    abort = 1'b0; start = 1'b0; cell_ack = 1'b0;
    chk("abort_cell_valid", cellValid, 0);
    chk("abort_busy", busy, 0);
    repeat (5) tick();
    chk("abort_no_frame_done", fdCount, fdBefore);
    chk("abort_stays_idle", busy, 0);
    start = 1'b1; tick(); start = 1'b0;
    chk("abort_restart_addr", address, 0);
    chk("abort_restart_valid", cellValid, 1);

    // Reset mid-frame.
    runTo(ABORT_ADDR);
    fdBefore = fdCount;
    resetn = 1'b0; #1;
    chk("reset_cell_valid", cellValid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_address", address, 0);
    tick();
    resetn = 1'b1;
    repeat (5) tick();
    chk("reset_no_autostart", busy, 0);
    chk("reset_no_frame_done", fdCount, fdBefore);
    cell_ack = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    chk("reset_restart_addr", address, 0);
    chk("reset_restart_valid", cellValid, 1);
    abort = 1'b1; tick(); abort = 1'b0;

    // Continuous mode over two frames.
    continuous = 1'b1;
    start = 1'b1; tick(); start = 1'b0; cell_ack = 1'b1;
    fdLocal = 0; prevFd = 1'b0;
    for (int i = 0; i < 2 * FRAME_LEN; i++) begin
      if (prevFd) chk("wrap_then_addr0", {cellValid, address}, {1'b1, 11'd0});
      prevFd  = frameDone;
      fdLocal += int'(frameDone);
      tick();
    end
    chk("cont_frame_done_pulses", fdLocal, 2);
    chk("cont_third_frame_addr0", {cellValid, address}, {1'b1, 11'd0});
    continuous = 1'b0; cell_ack = 1'b0;
    abort = 1'b1; tick(); abort = 1'b0;

    // 3x1 grid: row wrap, start while busy, ack while idle.
    start2 = 1'b1; tick(); start2 = 1'b0; ack2 = 1'b1;
    fdLocal = 0; prevCell2 = 1'b0; straight = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (!busy2) break;
      if (cellValid2 && (q2.size() == 0 || q2[$] != int'(address2))) q2.push_back(int'(address2));
      if (frameDone2) begin
        fdLocal++;
        straight = prevCell2;
      end
      prevCell2 = (cellValid2 || pixValid2) && address2 == 11'd2;
      start2 = (i == 1);
      tick();
    end
    start2 = 1'b0;
    chk("g3_cells", q2.size(), 3);
    for (int k = 0; k < 3 && k < q2.size(); k++) chk("g3_addr", q2[k], k);
    chk("g3_frame_done", fdLocal, 1);
    chk("g3_straight_to_wrap", straight, 1);
    chk("g3_idle", busy2, 0);
    repeat (4) begin
      tick();
      chk("g3_ack_in_idle_busy", busy2, 0);
      chk("g3_ack_in_idle_valid", cellValid2, 0);
    end
    ack2 = 1'b0;
    start2 = 1'b1; tick(); start2 = 1'b0;
    chk("g3_restart", {cellValid2, address2, posX2}, {1'b1, 11'd0, 8'd0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
`default_nettype wire
